// File: rtl/path_trace_pkg.sv
// Shared types for the router path-trace monitor: port ids, the per-port
// tracking state, and the trace record that leaves through the FIFO.
package path_trace_pkg;

  localparam int unsigned PT_NPORT  = 5;
  localparam int unsigned PT_ADDR_W = 16;
  localparam int unsigned PT_LEN_W  = 16;
  localparam int unsigned PT_TS_W   = 16;
  localparam int unsigned PT_PORT_W = $clog2(PT_NPORT);

  typedef enum logic [2:0] {
    PORT_E = 3'd0,
    PORT_W = 3'd1,
    PORT_N = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SIZE = 3'd2,
    ST_BODY = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [PT_PORT_W-1:0] port;
    logic [PT_ADDR_W-1:0] addr;
    logic [PT_LEN_W-1:0]  size;
    logic [PT_TS_W-1:0]   lat;
  } trace_rec_t;

endpackage

// File: rtl/path_rec_fifo.sv
// Synchronous FIFO of trace records; head is presented combinationally and
// reads as all-zero while empty.
module path_rec_fifo
  import path_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t wdata_i,
  output trace_rec_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    full_o  = (cnt_q == CW'(DEPTH));
    empty_o = (cnt_q == '0);
    do_pop  = pop_i & ~empty_o;
    // a full FIFO still takes a push when the head leaves in the same cycle
    do_push = push_i & (~full_o | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    rdata_o = empty_o ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/path_trace_monitor.sv
// Router path-trace monitor: follows each output-port packet from allocation
// to last flit and queues one trace record per completed packet.
module path_trace_monitor
  import path_trace_pkg::*;
#(
  parameter int unsigned NPORT     = PT_NPORT,
  parameter int unsigned FLIT_W    = 32,
  parameter int unsigned ADDR_W    = PT_ADDR_W,
  parameter int unsigned FIXED_LEN = 4,
  parameter int unsigned LEN_W     = PT_LEN_W,
  parameter int unsigned TS_W      = PT_TS_W,
  parameter int unsigned REC_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NPORT-1:0]               h_ack,
  input  logic [NPORT-1:0]               free_i,
  input  logic [ADDR_W-1:0]              address_i,
  input  logic [NPORT-1:0][FLIT_W-1:0]   data_i,
  input  logic [NPORT-1:0]               xfer_i,
  output logic                           rec_valid_o,
  input  logic                           rec_ready_i,
  output trace_rec_t                     rec_o,
  output logic [15:0]                    drop_cnt_o,
  output logic [NPORT-1:0]               busy_o
);

  localparam int unsigned DW = $clog2(NPORT + 1);
  localparam logic [LEN_W-1:0] FIX_SIZE = (FIXED_LEN >= 2) ? LEN_W'(FIXED_LEN - 2) : '0;

  logic [NPORT-1:0]     free_q, free_d;
  logic [NPORT-1:0]     alloc, req, grant, drop_evt;
  trace_rec_t           rec_w [NPORT];
  logic [PT_PORT_W-1:0] sel;
  logic                 found, push, pop, fifo_full, fifo_empty;
  logic [15:0]          drop_q, drop_d;
  logic [DW-1:0]        ndrop;
  logic [16:0]          drop_sum;
  logic                 unused_data;

  assign unused_data = ^data_i;
  assign alloc       = {NPORT{|h_ack}} & free_q & ~free_i;
  assign free_d      = free_i;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, size_q, size_d;
    logic [TS_W-1:0]   lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    total;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      total   = (FIXED_LEN == 0) ? ({1'b0, size_q} + (LEN_W+1)'(2)) : (LEN_W+1)'(FIXED_LEN);
      if (alloc[p]) begin
        // fresh allocation always restarts, even over a held or partial packet
        state_d = ST_HDR;
        cnt_d   = '0;
        size_d  = '0;
        lat_d   = '0;
        addr_d  = address_i;
      end else begin
        if ((state_q == ST_HDR || state_q == ST_SIZE || state_q == ST_BODY) && lat_q != '1)
          lat_d = lat_q + 1'b1;
        case (state_q)
          ST_HDR: if (xfer_i[p]) begin
            cnt_d = LEN_W'(1);
            if (FIXED_LEN == 1)      state_d = ST_DONE;
            else if (FIXED_LEN == 0) state_d = ST_SIZE;
            else                     state_d = ST_BODY;
          end
          ST_SIZE: if (xfer_i[p]) begin
            size_d  = data_i[p][LEN_W-1:0];
            cnt_d   = LEN_W'(2);
            state_d = (data_i[p][LEN_W-1:0] == '0) ? ST_DONE : ST_BODY;
          end
          ST_BODY: if (xfer_i[p]) begin
            cnt_d = cnt_q + 1'b1;
            if (({1'b0, cnt_q} + 1'b1) == total) state_d = ST_DONE;
          end
          ST_DONE: if (grant[p]) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        size_q  <= '0;
        lat_q   <= '0;
        addr_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        size_q  <= size_d;
        lat_q   <= lat_d;
        addr_q  <= addr_d;
      end
    end

    assign busy_o[p]   = (state_q != ST_IDLE);
    assign req[p]      = (state_q == ST_DONE) & ~alloc[p];
    assign drop_evt[p] = alloc[p] & (state_q != ST_IDLE);
    assign rec_w[p]    = {PT_PORT_W'(p), addr_q, (FIXED_LEN == 0) ? size_q : FIX_SIZE, lat_q};
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        sel   = PT_PORT_W'(i);
      end
    end
    pop   = rec_valid_o & rec_ready_i;
    push  = found & (~fifo_full | pop);
    grant = '0;
    if (push) grant[sel] = 1'b1;
  end

  always_comb begin
    ndrop = '0;
    for (int unsigned i = 0; i < NPORT; i++) ndrop = ndrop + DW'(drop_evt[i]);
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
    drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q <= '1;
      drop_q <= '0;
    end else begin
      free_q <= free_d;
      drop_q <= drop_d;
    end
  end

  path_rec_fifo #(.DEPTH(REC_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_w[sel]),
    .rdata_o (rec_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid_o = ~fifo_empty;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_path_trace_monitor.sv
// Bench for path_trace_monitor: a fixed-length (4) and a size-flit (0)
// instance share stimulus and are checked against a packet-level model.
module tb_path_trace_monitor;
  import path_trace_pkg::*;

  localparam int unsigned NP    = 5;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset;
  logic [NP-1:0]        h_ack, free_i, xfer_i;
  logic [15:0]          address_i;
  logic [NP-1:0][31:0]  data_i;
  logic                 rec_ready_i;
  logic                 vld  [2];
  trace_rec_t           rec  [2];
  logic [15:0]          drop [2];
  logic [NP-1:0]        busy [2];

  path_trace_monitor #(.FIXED_LEN(4)) u_fix (
    .clock(clock), .reset(reset), .h_ack(h_ack), .free_i(free_i),
    .address_i(address_i), .data_i(data_i), .xfer_i(xfer_i),
    .rec_valid_o(vld[0]), .rec_ready_i(rec_ready_i), .rec_o(rec[0]),
    .drop_cnt_o(drop[0]), .busy_o(busy[0]));

  path_trace_monitor #(.FIXED_LEN(0)) u_var (
    .clock(clock), .reset(reset), .h_ack(h_ack), .free_i(free_i),
    .address_i(address_i), .data_i(data_i), .xfer_i(xfer_i),
    .rec_valid_o(vld[1]), .rec_ready_i(rec_ready_i), .rec_o(rec[1]),
    .drop_cnt_o(drop[1]), .busy_o(busy[1]));

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  // packet-level reference: flits seen, alloc/last-flit cycle, queued records
  logic [NP-1:0] m_free_r;
  bit            m_act  [2][NP];
  bit            m_done [2][NP];
  int unsigned   m_n    [2][NP];
  int unsigned   m_size [2][NP];
  int unsigned   m_t0   [2][NP];
  int unsigned   m_lat  [2][NP];
  logic [15:0]   m_addr [2][NP];
  int unsigned   m_drop [2];
  trace_rec_t    q0[$], q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic trace_rec_t qhead(input int m);
    if (m == 0) return (q0.size() > 0) ? q0[0] : '0;
    return (q1.size() > 0) ? q1[0] : '0;
  endfunction

  task automatic model_step();
    logic [NP-1:0] alloc;
    alloc = {NP{|h_ack}} & m_free_r & ~free_i;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < NP; p++) begin
          m_act[m][p] = 0; m_done[m][p] = 0; m_n[m][p] = 0;
        end
        m_drop[m] = 0;
      end
      q0.delete(); q1.delete();
      m_free_r = '1;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      int unsigned fl;
      bit          pop, can;
      int          win;
      trace_rec_t  r;
      fl  = (m == 0) ? 4 : 0;
      pop = (qsize(m) > 0) && rec_ready_i;
      can = (qsize(m) < DEPTH) || pop;
      win = -1;
      for (int p = 0; p < NP; p++)
        if (m_done[m][p] && !alloc[p] && win < 0) win = p;
      if (!can) win = -1;
      r = '0;
      if (win >= 0) begin
        r.port = 3'(win);
        r.addr = m_addr[m][win];
        r.size = (fl != 0) ? 16'(fl - 2) : 16'(m_size[m][win]);
        r.lat  = 16'(m_lat[m][win]);
      end
      for (int p = 0; p < NP; p++) begin
        if (alloc[p]) begin
          if (m_act[m][p] || m_done[m][p]) m_drop[m] = (m_drop[m] < 65535) ? m_drop[m] + 1 : 65535;
          m_act[m][p] = 1; m_done[m][p] = 0; m_n[m][p] = 0; m_size[m][p] = 0;
          m_addr[m][p] = address_i; m_t0[m][p] = cyc;
        end else if (m_done[m][p]) begin
          if (win == p) m_done[m][p] = 0;
        end else if (m_act[m][p] && xfer_i[p]) begin
          m_n[m][p]++;
          if (fl == 0 && m_n[m][p] == 2) m_size[m][p] = int'(data_i[p] & 32'h0000_FFFF);
          if ((fl != 0 && m_n[m][p] == fl) ||
              (fl == 0 && m_n[m][p] >= 2 && m_n[m][p] == m_size[m][p] + 2)) begin
            m_act[m][p]  = 0;
            m_done[m][p] = 1;
            m_lat[m][p]  = (cyc - m_t0[m][p] > 65535) ? 65535 : cyc - m_t0[m][p];
          end
        end
      end
      if (m == 0) begin
        if (pop) void'(q0.pop_front());
        if (win >= 0) q0.push_back(r);
      end else begin
        if (pop) void'(q1.pop_front());
        if (win >= 0) q1.push_back(r);
      end
    end
    m_free_r = free_i;
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      logic [NP-1:0] eb;
      eb = '0;
      for (int p = 0; p < NP; p++) eb[p] = m_act[m][p] | m_done[m][p];
      check($sformatf("model_valid%0d", m), 64'(vld[m]), 64'(qsize(m) > 0));
      check($sformatf("model_rec%0d", m),   64'(rec[m]), 64'(qhead(m)));
      check($sformatf("model_busy%0d", m),  64'(busy[m]), 64'(eb));
      check($sformatf("model_drop%0d", m),  64'(drop[m]), 64'(m_drop[m]));
    end
  endtask

  task automatic idle_inputs();
    h_ack = '0; xfer_i = '0; data_i = '0; rec_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    free_i = '1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_pkt(input int p, input logic [15:0] addr);
    free_i[p] = 1'b0; h_ack = 5'h01; address_i = addr;
    step();
    h_ack = '0;
    for (int k = 0; k < 4; k++) begin
      xfer_i[p] = 1'b1;
      step();
    end
    xfer_i[p] = 1'b0; free_i[p] = 1'b1;
    step();
    step();
  endtask

  task automatic wait_valid(input int m, input int bound, input string name);
    int i;
    i = 0;
    while (!vld[m] && i < bound) begin
      step();
      i++;
    end
    check({name, "_valid"}, 64'(vld[m]), 64'(1));
  endtask

  typedef struct {
    logic [4:0] free;
    logic [4:0] hack;
    logic [4:0] xfer;
    logic       rdy;
    logic [4:0] busy;
    logic       valid;
    trace_rec_t rec;
  } vec_t;

  vec_t       tbl [7];
  trace_rec_t got [$];
  int unsigned gcyc [$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; free_i = '1; address_i = '0; m_free_r = '1;
    idle_inputs();
    do_reset();
    check("reset_valid", 64'(vld[0]), 64'(0));
    check("reset_rec",   64'(rec[0]), 64'(0));
    check("reset_drop",  64'(drop[0]), 64'(0));
    check("reset_busy",  64'(busy[0]), 64'(0));

    // fixed length 4 on E, cycle by cycle
    tbl[0] = '{free:5'h1E, hack:5'h01, xfer:5'h00, rdy:1'b0, busy:5'h01, valid:1'b0, rec:'0};
    tbl[1] = '{free:5'h1E, hack:5'h00, xfer:5'h01, rdy:1'b0, busy:5'h01, valid:1'b0, rec:'0};
    tbl[2] = '{free:5'h1E, hack:5'h00, xfer:5'h01, rdy:1'b0, busy:5'h01, valid:1'b0, rec:'0};
    tbl[3] = '{free:5'h1E, hack:5'h00, xfer:5'h01, rdy:1'b0, busy:5'h01, valid:1'b0, rec:'0};
    tbl[4] = '{free:5'h1E, hack:5'h00, xfer:5'h01, rdy:1'b0, busy:5'h01, valid:1'b0, rec:'0};
    tbl[5] = '{free:5'h1E, hack:5'h00, xfer:5'h00, rdy:1'b0, busy:5'h00, valid:1'b1,
               rec:'{port:3'd0, addr:16'h0102, size:16'd2, lat:16'd4}};
    tbl[6] = '{free:5'h1F, hack:5'h00, xfer:5'h00, rdy:1'b1, busy:5'h00, valid:1'b0, rec:'0};
    address_i = 16'h0102;
    for (int i = 0; i < 7; i++) begin
      free_i = tbl[i].free; h_ack = tbl[i].hack; xfer_i = tbl[i].xfer; rec_ready_i = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_busy", i),  64'(busy[0]), 64'(tbl[i].busy));
      check($sformatf("tbl%0d_valid", i), 64'(vld[0]),  64'(tbl[i].valid));
      check($sformatf("tbl%0d_rec", i),   64'(rec[0]),  64'(tbl[i].rec));
      check($sformatf("tbl%0d_drop", i),  64'(drop[0]), 64'(0));
    end
    idle_inputs();

    // size flit = 3 on N, flits two cycles apart
    do_reset();
    free_i[2] = 1'b0; h_ack = 5'h04; address_i = 16'h0203;
    step();
    h_ack = '0;
    for (int k = 0; k < 5; k++) begin
      xfer_i[2] = 1'b1; data_i[2] = (k == 1) ? 32'h5A5A_0003 : 32'hABCD_0000;
      step();
      xfer_i[2] = 1'b0; data_i[2] = '0;
      if (k < 4) step();
    end
    wait_valid(1, 10, "size3");
    check("size3_rec", 64'(rec[1]), 64'({3'd2, 16'h0203, 16'd3, 16'd9}));
    rec_ready_i = 1'b1; step(); rec_ready_i = 1'b0;

    // size flit = 0 completes after two flits
    do_reset();
    free_i[2] = 1'b0; h_ack = 5'h02; address_i = 16'h0707;
    step();
    h_ack = '0;
    xfer_i[2] = 1'b1; step(); step();
    xfer_i[2] = 1'b0;
    wait_valid(1, 10, "size0");
    check("size0_rec", 64'(rec[1]), 64'({3'd2, 16'h0707, 16'd0, 16'd2}));

    // W and S finish together: W record first, S on the next cycle
    do_reset();
    free_i = 5'b10101; h_ack = 5'h01; address_i = 16'h0304;
    step();
    h_ack = '0;
    for (int k = 0; k < 4; k++) begin xfer_i = 5'b01010; step(); end
    xfer_i = '0; rec_ready_i = 1'b1;
    got.delete(); gcyc.delete();
    for (int i = 0; i < 8 && got.size() < 2; i++) begin
      if (vld[0]) begin got.push_back(rec[0]); gcyc.push_back(cyc); end
      step();
    end
    check("ws_count", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      check("ws_first",  64'(got[0]), 64'({3'd1, 16'h0304, 16'd2, 16'd4}));
      check("ws_second", 64'(got[1]), 64'({3'd3, 16'h0304, 16'd2, 16'd4}));
      check("ws_gap",    64'(gcyc[1] - gcyc[0]), 64'(1));
    end
    idle_inputs(); free_i = '1; step();

    // fill the FIFO, then overwrite a held L record
    do_reset();
    for (int i = 0; i < 4; i++) run_pkt(0, 16'hA000 + 16'(i));
    check("full_valid", 64'(vld[0]), 64'(1));
    free_i[4] = 1'b0; h_ack = 5'h01; address_i = 16'hB000;
    step();
    h_ack = '0;
    for (int k = 0; k < 4; k++) begin xfer_i[4] = 1'b1; step(); end
    xfer_i[4] = 1'b0; free_i[4] = 1'b1;
    step();
    free_i[4] = 1'b0; h_ack = 5'h01; address_i = 16'hB001;
    step();
    h_ack = '0;
    step();
    check("full_drop", 64'(drop[0]), 64'(1));
    check("full_busy", 64'(busy[0]), 64'(5'h10));
    check("full_head", 64'(rec[0]), 64'({3'd0, 16'hA000, 16'd2, 16'd4}));
    rec_ready_i = 1'b1;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 4; i++) begin
      if (vld[0]) got.push_back(rec[0]);
      step();
    end
    check("drain_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size(); i++)
      check($sformatf("drain%0d_addr", i), 64'(got[i].addr), 64'(16'hA000 + 16'(i)));
    check("drain_empty", 64'(vld[0]), 64'(0));
    idle_inputs(); free_i = '1; step();

    // reset in the middle of a packet abandons it
    do_reset();
    free_i[0] = 1'b0; h_ack = 5'h01; address_i = 16'h0444;
    step();
    h_ack = '0;
    xfer_i[0] = 1'b1; step(); step();
    xfer_i[0] = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", 64'(busy[0]), 64'(0));
    step(); step(); step();
    check("rst_norec", 64'(vld[0]), 64'(0));
    free_i[0] = 1'b1; step();
    run_pkt(0, 16'h0555);
    wait_valid(0, 6, "after_rst");
    check("after_rst_rec", 64'(rec[0]), 64'({3'd0, 16'h0555, 16'd2, 16'd4}));

    // idle transfers and un-acknowledged free drops change nothing
    do_reset();
    xfer_i = '1; step(); step(); step();
    xfer_i = '0;
    check("idle_xfer_busy", 64'(busy[0] | busy[1]), 64'(0));
    free_i = '0; step(); step();
    check("noack_busy",  64'(busy[0] | busy[1]), 64'(0));
    check("noack_valid", 64'(vld[0] | vld[1]), 64'(0));
    free_i = '1; step();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 499) == 0);
      h_ack       = ($urandom_range(0, 2) == 0) ? 5'($urandom()) : 5'h00;
      address_i   = 16'($urandom());
      xfer_i      = 5'($urandom());
      rec_ready_i = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) begin
        if (free_i[p]) begin
          if ($urandom_range(0, 9) == 0) free_i[p] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) free_i[p] = 1'b1;
        data_i[p] = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/path_trace_monitor.md
Name: path_trace_monitor

Overview:
- Synthesizable, parametrised successor to the router path logger. Sits beside one router and watches its output-port allocation (free/h_ack) and per-port flit transfers.
- Per output port, it tracks each packet from allocation to last flit. Packet length is either fixed or taken from the size flit.
- It emits one trace record per completed packet through a small FIFO with a valid/ready handshake. It never stalls the router.

Parameters:
- NPORT, 5, number of router output ports. Index order is E=0, W=1, N=2, S=3, L=4.
- FLIT_W, 32, flit data width.
- ADDR_W, 16, header address width: [ADDR_W-1:ADDR_W/2] is X, low half is Y.
- FIXED_LEN, 4, total flits per packet. 0 means the length comes from the 2nd flit: total = size + 2.
- LEN_W, 16, flit-counter and size width.
- TS_W, 16, latency counter width.
- REC_DEPTH, 4, record FIFO depth. Must be a power of 2, minimum 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- h_ack  in  NPORT  router header-acknowledge.
- free_i  in  NPORT  port free flags; 1 = free.
- address_i  in  ADDR_W  header target address of the packet being routed.
- data_i  in  NPORT x FLIT_W  flit on each output port.
- xfer_i  in  NPORT  flit accepted on port p this cycle (tx & credit).
- rec_valid_o  out  1  record available.
- rec_ready_i  in  1  consumer accepts the record.
- rec_o  out  trace_rec_t  {port, address, size, latency}.
- drop_cnt_o  out  16  records lost, saturating.
- busy_o  out  NPORT  port p is tracking a packet.

Behaviour:
- Reset clears:
  - free_r to all-ones.
  - Every port FSM to IDLE and every counter to 0.
  - The FIFO to empty, so rec_valid_o = 0 and rec_o = 0.
  - drop_cnt_o = 0 and busy_o = 0.
- Reset mid-packet abandons the packet with no record.
- free_r is a registered copy of free_i.
- alloc[p] = (h_ack != 0) & free_r[p] & ~free_i[p]. Several ports may allocate in the same cycle; each is handled independently.
- Per-port FSM with states IDLE, HDR, SIZE, BODY, DONE:
  - IDLE: on alloc[p], capture address_i, clear the flit counter, set latency = 0, go to HDR.
  - HDR: on xfer_i[p], count 1. If FIXED_LEN = 0 go to SIZE, else go to BODY.
  - SIZE: on xfer_i[p], latch size = data_i[p][LEN_W-1:0] and count 2. Go to BODY, or straight to DONE if size = 0.
  - BODY: count each xfer_i[p]. On the flit that reaches the total (FIXED_LEN, or size+2), go to DONE.
  - FIXED_LEN = 1 goes HDR->DONE.
  - DONE: holds the record until the FIFO accepts it, then goes to IDLE.
- busy_o[p] is 1 in every state except IDLE.
- Latency counts from the alloc cycle (value 0) up to and including the last-flit cycle. It saturates at 2^TS_W-1.
- Record size field: the latched size, or FIXED_LEN-2 in fixed mode (clamped to 0).
- FIFO push: at most one record per cycle. DONE ports are served lowest-index-first. A push is allowed when the FIFO is not full, or when it is full and popped in the same cycle.
- Pop happens when rec_valid_o & rec_ready_i. rec_o comes straight from the FIFO head with no added latency. Push and pop in the same cycle keep the occupancy unchanged.
- Drop: alloc[p] while port p is in DONE overwrites the held record. The port restarts at HDR and drop_cnt_o increments, saturating at 0xFFFF.
- Boundary cases:
  - xfer_i[p] in IDLE is ignored.
  - alloc[p] in HDR/SIZE/BODY is a protocol error. Restart the packet and increment drop_cnt_o.
- Minimum record latency: alloc at cycle t, first transfer at t+1, rec_valid_o rising at (last flit)+2. The extra cycles are the DONE push and the FIFO write.

Decomposition:
- path_trace_pkg holds:
  - The port_e enum (E, W, N, S, L).
  - The trace_rec_t struct {logic [$clog2(NPORT)-1:0] port; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] size; logic [TS_W-1:0] lat}.
  - The state enum.
- Sub-module path_rec_fifo: a generic synchronous FIFO of trace_rec_t with push/pop/full/empty and REC_DEPTH.
- The per-port FSM is a generate loop in the top module.

Test Plan:
- Fixed length 4 on E: free_i 11111->11110 with h_ack=1 and address_i=16'h0102, then 4 xfer_i[0] on consecutive cycles -> one record {port 0, addr 0x0102, size 2, lat 4}, drop_cnt_o = 0.
- FIXED_LEN=0 on N: size flit = 3, so 5 flits total, with xfer gaps of 2 cycles -> record {port 2, size 3, lat 9}. A size flit of 0 gives size 0 after 2 flits.
- Simultaneous completion on W and S in the same cycle -> records come out W first, then S, on consecutive cycles with rec_ready_i = 1.
- Hold rec_ready_i = 0 until the FIFO is full (4 records), then complete L and re-allocate L -> drop_cnt_o = 1 and FIFO contents unchanged. Releasing ready drains 4 records in order.
- Assert reset mid-BODY on E -> busy_o = 0 next cycle and no record emitted. The next packet is traced normally.
- xfer_i on an idle port, plus h_ack=0 while free falls -> no state change and no record.
